mem_rd_responder: RTL and testbench
===================================

# mem_rd_responder

Memory read responder for the multi-cycle CPU. It accepts a read request from the control unit, drives a word-addressed memory for a fixed number of wait cycles, and captures the returned word. It then presents the word with a one-cycle valid pulse to the datapath temp register (MDR) that latches it. Misaligned addresses are rejected with an error pulse and produce no memory access.

## Interface
Parameters:
- WAIT_CYCLES, 2: memory settle cycles after the address is presented; legal range 0–15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_req  in  1  read request; sampled only while rd_ready=1.
- rd_addr  in  32  byte address; sampled with rd_req.
- rd_ready  out  1  block idle and able to accept a request.
- rd_valid  out  1  one-cycle pulse; rd_data/rd_err are valid in that cycle.
- rd_data  out  32  last successfully read word; held until the next successful read.
- rd_err  out  1  high together with rd_valid when the accepted address had rd_addr[1:0]≠0.
- mem_en  out  1  memory access enable.
- mem_addr  out  30  word address, equal to the latched rd_addr[31:2].
- mem_rdata  in  32  memory read data; combinational from mem_addr, settled after WAIT_CYCLES cycles.

## Operation
- Three-state FSM: IDLE, ACCESS, DONE.
- IDLE:
  - rd_ready=1, mem_en=0.
  - rd_req=1 at a clock edge latches rd_addr.
  - If addr[1:0]≠0: err flag set, go to DONE.
  - Otherwise: err flag cleared, cnt loaded with WAIT_CYCLES, go to ACCESS.
- ACCESS:
  - mem_en=1 and mem_addr=latched word address, stable for the whole state.
  - cnt decrements each edge.
  - At the edge where cnt==0: rd_data<=mem_rdata, go to DONE.
- DONE:
  - rd_valid=1, rd_err=err flag, for exactly one cycle.
  - Go to IDLE unconditionally. rd_req is ignored in this state.
- rd_data is updated only by a successful read. An error transaction leaves it unchanged.
- cnt is 4 bits. No wrap: it is loaded only from IDLE and stops at 0.
- rd_ready, rd_valid and mem_en are decoded from the state register (Moore outputs). rd_err is registered.

## Timing
- Reset values (immediate on reset=0, independent of clk):
  - state=IDLE, so rd_ready=1.
  - rd_valid=0, rd_err=0, rd_data=32'h0, mem_en=0, mem_addr=0, cnt=0.
- While reset=0, rd_req is ignored.
- Reset asserted in ACCESS or DONE aborts the transaction. No rd_valid is produced for it, and rd_data returns to 0.
- Aligned read: request accepted at edge E0. mem_en is high for WAIT_CYCLES+1 cycles. rd_valid is high in the cycle after edge E0+WAIT_CYCLES+1, so request-to-valid latency is WAIT_CYCLES+2 cycles.
- WAIT_CYCLES=0: mem_en is high for 1 cycle and rd_valid follows on the next cycle.
- Misaligned read: rd_valid=rd_err=1 in the cycle immediately after acceptance, and mem_en never rises.
- Throughput: at most one accepted request per WAIT_CYCLES+3 cycles. rd_ready returns to 1 in the cycle after rd_valid.
- rd_req held high continuously is accepted again on the first IDLE edge. No queueing.
- rd_addr changes during ACCESS have no effect on mem_addr.

## Structure
- Shared CPU package:
  - the state enum (IDLE/ACCESS/DONE);
  - the constant WORD_BYTES=4;
  - the alignment-mask constant 2'b00.
- No sub-module. The wait counter and FSM stay inline in a single always block, plus combinational output decode.

## Test plan
- Reset mid-ACCESS (WAIT_CYCLES=2): drop reset one cycle after acceptance → all outputs return to reset values with no clock edge needed. No rd_valid pulse appears. After release, rd_ready=1.
- Aligned read, WAIT_CYCLES=2:
  - Stimulus: rd_addr=32'h0000_0010; memory word 4 = 32'hDEAD_BEEF.
  - Response: mem_addr=30'h4 and mem_en=1 for 3 cycles. rd_valid pulses once, 4 cycles after acceptance, with rd_data=32'hDEAD_BEEF and rd_err=0.
- Misaligned read: rd_addr=32'h0000_0013 after the previous read → next cycle rd_valid=1 and rd_err=1. rd_data stays 32'hDEAD_BEEF and mem_en stays 0.
- Back-to-back: rd_req held high with addresses 32'h0 then 32'h4 → second acceptance occurs exactly WAIT_CYCLES+3 cycles after the first. Two rd_valid pulses carry the respective words.
- WAIT_CYCLES=0, rd_addr=32'hFFFF_FFFC → mem_addr=30'h3FFF_FFFF for 1 cycle, then rd_valid on the following cycle.
- Address stability: change rd_addr during ACCESS → mem_addr unchanged and the captured data matches the originally latched address.

Source files
------------

// File: rtl/mem_rd_responder_pkg.sv
// rtl/mem_rd_responder_pkg.sv - shared CPU constants and types for the memory read responder
package mem_rd_responder_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam int OFFSET_BITS = $clog2(WORD_BYTES);
  localparam logic [1:0] ALIGN_MASK = 2'b00;

  // A byte address is usable only when its in-word offset is zero
  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[OFFSET_BITS-1:0] == ALIGN_MASK;
  endfunction

endpackage

// File: rtl/mem_rd_responder.sv
// rtl/mem_rd_responder.sv - word memory read responder with fixed wait states and one-cycle result pulse
module mem_rd_responder
  import mem_rd_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_ready,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        rd_err,
  output logic        mem_en,
  output logic [29:0] mem_addr,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] ACCESS = ST_ACCESS;
  localparam logic [1:0] DONE   = ST_DONE;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       err_flag;

  // FSM, wait counter, address latch and result capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      err_flag <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= 32'h0;
      mem_addr <= 30'h0;
    end else begin
      case (state)
        IDLE: begin
          rd_err <= 1'b0;
          if (rd_req) begin
            mem_addr <= rd_addr[31:OFFSET_BITS];
            if (!is_aligned(rd_addr)) begin
              // Misaligned: no memory access, report straight away
              err_flag <= 1'b1;
              rd_err   <= 1'b1;
              state    <= DONE;
            end else begin
              err_flag <= 1'b0;
              cnt      <= WAIT_INIT;
              state    <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            rd_data <= mem_rdata;
            rd_err  <= err_flag;
            state   <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          // Result is shown for one cycle only; requests here are ignored
          rd_err <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          rd_err <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Moore output decode from the state register
  always_comb begin
    rd_ready = (state == IDLE);
    rd_valid = (state == DONE);
    mem_en   = (state == ACCESS);
  end

endmodule

// File: tb/tb_mem_rd_responder.sv
// tb/tb_mem_rd_responder.sv - self-checking bench for mem_rd_responder
module tb_mem_rd_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset;

  logic        rd_req, rd_ready, rd_valid, rd_err, mem_en;
  logic [31:0] rd_addr, rd_data, mem_rdata;
  logic [29:0] mem_addr;

  logic        rd_req0, rd_ready0, rd_valid0, rd_err0, mem_en0;
  logic [31:0] rd_addr0, rd_data0, mem_rdata0;
  logic [29:0] mem_addr0;

  logic [31:0] mem [0:255];
  logic [31:0] model_data;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign mem_rdata  = mem[mem_addr[7:0]];
  assign mem_rdata0 = mem[mem_addr0[7:0]];

  mem_rd_responder #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  mem_rd_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .rd_req(rd_req0), .rd_addr(rd_addr0),
    .rd_ready(rd_ready0), .rd_valid(rd_valid0), .rd_data(rd_data0), .rd_err(rd_err0),
    .mem_en(mem_en0), .mem_addr(mem_addr0), .mem_rdata(mem_rdata0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_flags"}, {28'h0, rd_ready, rd_valid, rd_err, mem_en}, 32'h8);
    check({tag, "_rd_data"}, rd_data, 32'h0);
    check({tag, "_mem_addr"}, {2'b00, mem_addr}, 32'h0);
  endtask

  // One transaction: expected latency/enable count come from the caller,
  // expected data from the memory image and the last successful read.
  task automatic run_read(input logic [31:0] addr, input bit chg, input bit exp_err,
                          input int exp_lat, input int exp_men);
    int k, men, lat;
    bit bad_addr;
    logic got_err;
    logic [31:0] got_data, exp_data;
    got_err  = 1'bx;
    got_data = 'x;
    @(negedge clk);
    k = 0;
    while (k < 20 && !rd_ready) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_req", {31'h0, rd_ready}, 32'h1);
    rd_req  = 1'b1;
    rd_addr = addr;
    @(negedge clk);
    rd_req = 1'b0;
    k = 1; men = 0; lat = 0; bad_addr = 1'b0;
    while (k <= 40) begin
      if (mem_en) begin
        men++;
        if (mem_addr !== addr[31:2]) bad_addr = 1'b1;
        if (chg) rd_addr = $urandom;
      end
      if (rd_valid) begin
        lat      = k;
        got_err  = rd_err;
        got_data = rd_data;
        break;
      end
      @(negedge clk);
      k++;
    end
    exp_data   = exp_err ? model_data : mem[addr[9:2]];
    model_data = exp_data;
    check("latency", lat, exp_lat);
    check("rd_err", {31'h0, got_err}, {31'h0, exp_err});
    check("rd_data", got_data, exp_data);
    check("mem_en_cycles", men, exp_men);
    check("mem_addr_stable", {31'h0, bad_addr}, 32'h0);
    @(negedge clk);
    check("valid_one_cycle", {30'h0, rd_valid, rd_ready}, 32'h1);
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          chg;
    bit          err;
    int          lat;
    int          men;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int v1, v2, acc2;
    logic [31:0] d1, d2;
    bit seen;
    logic [31:0] a;
    bit e;

    tbl[0] = '{32'h0000_0040, 1'b0, 1'b0, W + 2, W + 1};
    tbl[1] = '{32'h0000_0041, 1'b0, 1'b1, 1, 0};
    tbl[2] = '{32'h0000_03FC, 1'b1, 1'b0, W + 2, W + 1};
    tbl[3] = '{32'h0000_0002, 1'b0, 1'b1, 1, 0};
    tbl[4] = '{32'h0000_0100, 1'b1, 1'b0, W + 2, W + 1};
    tbl[5] = '{32'h0000_0207, 1'b0, 1'b1, 1, 0};

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[4] = 32'hDEAD_BEEF;
    model_data = 32'h0;

    reset = 1'b0;
    rd_req = 1'b1; rd_addr = 32'h10;
    rd_req0 = 1'b0; rd_addr0 = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rd_req = 1'b0;
    reset = 1'b1;

    // Reset in the middle of an access
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 32'h20;
    @(negedge clk);
    rd_req = 1'b0;
    check("abort_mem_en", {31'h0, mem_en}, 32'h1);
    #2 reset = 1'b0;
    #1 check_reset_vals("abort");
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rd_valid) seen = 1'b1;
    end
    reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rd_valid) seen = 1'b1;
    end
    check("abort_no_valid", {31'h0, seen}, 32'h0);
    check("abort_ready", {31'h0, rd_ready}, 32'h1);
    model_data = 32'h0;

    // Aligned read then misaligned read
    run_read(32'h0000_0010, 1'b0, 1'b0, W + 2, W + 1);
    check("deadbeef", rd_data, 32'hDEAD_BEEF);
    run_read(32'h0000_0013, 1'b0, 1'b1, 1, 0);
    check("data_held", rd_data, 32'hDEAD_BEEF);

    // Back-to-back with rd_req held high
    @(negedge clk);
    while (!rd_ready) @(negedge clk);
    rd_req = 1'b1; rd_addr = 32'h0;
    v1 = -1; v2 = -1; acc2 = -1; d1 = 'x; d2 = 'x;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) rd_addr = 32'h4;
      if (rd_ready && acc2 < 0) acc2 = k;
      if (rd_valid && v1 < 0) begin
        v1 = k; d1 = rd_data;
      end else if (rd_valid && v2 < 0) begin
        v2 = k; d2 = rd_data; rd_req = 1'b0;
        break;
      end
    end
    rd_req = 1'b0;
    check("b2b_second_accept", acc2, W + 3);
    check("b2b_valid1", v1, W + 2);
    check("b2b_valid2", v2, (W + 3) + (W + 2));
    check("b2b_data1", d1, mem[0]);
    check("b2b_data2", d2, mem[1]);
    model_data = mem[1];

    // Table vectors
    for (int i = 0; i < 6; i++)
      run_read(tbl[i].addr, tbl[i].chg, tbl[i].err, tbl[i].lat, tbl[i].men);

    // Random transactions against the latency/data rules
    for (int i = 0; i < 24; i++) begin
      a = $urandom_range(0, 1023);
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      e = (a[1:0] != 2'b00);
      run_read(a, bit'($urandom_range(0, 1)), e, e ? 1 : W + 2, e ? 0 : W + 1);
    end

    // Zero wait cycles at the top of the address space
    @(negedge clk);
    rd_req0 = 1'b1; rd_addr0 = 32'hFFFF_FFFC;
    @(negedge clk);
    rd_req0 = 1'b0;
    check("w0_mem_en", {30'h0, mem_en0, rd_valid0}, 32'h2);
    check("w0_mem_addr", {2'b00, mem_addr0}, 32'h3FFF_FFFF);
    @(negedge clk);
    check("w0_valid", {29'h0, rd_valid0, rd_err0, mem_en0}, 32'h4);
    check("w0_data", rd_data0, mem[255]);
    @(negedge clk);
    check("w0_idle", {30'h0, rd_valid0, rd_ready0}, 32'h1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
